// File: rtl/ram_stream_pkg.sv
// ram_stream_pkg
//   Shared types and constants for the RAM byte-stream reader:
//   - state_t           : reader FSM states
//   - ADDR_W / DATA_W   : RAM byte address and data widths
//   - DEF_MAX_BYTE_ADDR : default last valid byte address of the RAM port
//   - next_byte_addr()  : address increment that wraps at the top of the RAM
package ram_stream_pkg;

    localparam int ADDR_W = 26;
    localparam int DATA_W = 8;

    localparam logic [ADDR_W-1:0] DEF_MAX_BYTE_ADDR = 26'h1FFFFFF;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        ISSUE      = 3'd1,
        WAIT_DATA  = 3'd2,
        DRAIN      = 3'd3,
        ABORT_WAIT = 3'd4
    } state_t;

    // Wraps max_addr -> 0 so a range with start > end walks across the top.
    function automatic logic [ADDR_W-1:0] next_byte_addr(
        input logic [ADDR_W-1:0] addr,
        input logic [ADDR_W-1:0] max_addr
    );
        return (addr == max_addr) ? '0 : addr + ADDR_W'(1);
    endfunction

endpackage

// File: rtl/ram_stream_reader_fifo.sv
// sync_byte_fifo
//   Single-clock FIFO with first-word-fall-through output (dout is the head
//   whenever empty is low).
//   Ports:
//     clk, reset (async, active-low)
//     flush        : synchronous clear, wins over push/pop in the same cycle
//     push, din    : write side (ignored when full)
//     pop, dout    : read side (ignored when empty)
//     count        : number of stored entries, 0..DEPTH
//     full, empty  : status flags derived from count
module sync_byte_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   push,
    input  logic [WIDTH-1:0]       din,
    input  logic                   pop,
    output logic [WIDTH-1:0]       dout,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; validity is tracked entirely by count.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/ram_stream_reader.sv
// ram_stream_reader
//   Reads an inclusive byte range [start_addr .. end_addr] from a RAM port one
//   byte at a time (single outstanding read) and streams it out through a
//   small byte FIFO with a valid/ready handshake.
//   Ports:
//     clk, reset            : clock, async active-low reset
//     start, start_addr,
//     end_addr, abort       : transfer control (start/abort are 1-cycle pulses)
//     busy, done            : status; done pulses once the last byte has left
//     ram_rdy               : RAM calibrated, reads may be issued
//     ram_address           : byte address, held from request through ack
//     ram_read_request      : 1-cycle read command
//     ram_rd_data_pres      : RAM read FIFO non-empty
//     ram_read_ack          : 1-cycle pop of the RAM read FIFO
//     ram_data              : byte selected by the RAM port from ram_address
//     out_data, out_valid,
//     out_ready             : output byte stream
module ram_stream_reader
    import ram_stream_pkg::*;
#(
    parameter int                FIFO_DEPTH    = 16,
    parameter logic [ADDR_W-1:0] MAX_BYTE_ADDR = DEF_MAX_BYTE_ADDR
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W-1:0] end_addr,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    input  logic              ram_rdy,
    output logic [ADDR_W-1:0] ram_address,
    output logic              ram_read_request,
    input  logic              ram_rd_data_pres,
    output logic              ram_read_ack,
    input  logic [DATA_W-1:0] ram_data,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    state_t            state;
    logic [ADDR_W-1:0] cur_addr;
    logic [ADDR_W-1:0] last_addr;

    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_flush;
    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_full;
    logic              fifo_empty;
    logic              data_here;
    logic              can_issue;

    // A read is only issued with a free FIFO slot, so the single byte in
    // flight always has somewhere to land.
    assign can_issue = ram_rdy && (fifo_count < CNT_W'(FIFO_DEPTH));

    // The ack has to be in the same cycle the data is seen, so it is decoded
    // from state rather than registered. In ABORT_WAIT the byte is popped
    // from the RAM and dropped.
    assign data_here    = ram_rd_data_pres &&
                          ((state == WAIT_DATA) || (state == ABORT_WAIT));
    assign ram_read_ack = data_here;

    assign fifo_push  = (state == WAIT_DATA) && ram_rd_data_pres && !abort && !fifo_full;
    assign fifo_pop   = out_valid && out_ready;
    // Abort clears the FIFO at once; ABORT_WAIT clears again on its exit in
    // case anything is left (nothing is pushed there, so it is belt and braces).
    assign fifo_flush = (abort && (state != ABORT_WAIT)) ||
                        ((state == ABORT_WAIT) && ram_rd_data_pres);

    assign out_valid = !fifo_empty;

    sync_byte_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (fifo_flush),
        .push  (fifo_push),
        .din   (ram_data),
        .pop   (fifo_pop),
        .dout  (out_data),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state            <= IDLE;
            cur_addr         <= '0;
            last_addr        <= '0;
            busy             <= 1'b0;
            done             <= 1'b0;
            ram_read_request <= 1'b0;
            ram_address      <= '0;
        end else begin
            done             <= 1'b0;
            ram_read_request <= 1'b0;
            case (state)
                IDLE: begin
                    // abort beats a coincident start
                    if (!abort && start) begin
                        cur_addr  <= start_addr;
                        last_addr <= end_addr;
                        busy      <= 1'b1;
                        state     <= ISSUE;
                    end
                end

                ISSUE: begin
                    if (abort) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (can_issue) begin
                        // ram_address is not touched again until the next
                        // ISSUE, so it stays put through the ack.
                        ram_read_request <= 1'b1;
                        ram_address      <= cur_addr;
                        state            <= WAIT_DATA;
                    end
                end

                WAIT_DATA: begin
                    if (ram_rd_data_pres) begin
                        if (abort) begin
                            busy  <= 1'b0;
                            state <= IDLE;
                        end else if (cur_addr == last_addr) begin
                            state <= DRAIN;
                        end else begin
                            cur_addr <= next_byte_addr(cur_addr, MAX_BYTE_ADDR);
                            state    <= ISSUE;
                        end
                    end else if (abort) begin
                        state <= ABORT_WAIT;
                    end
                end

                DRAIN: begin
                    if (abort) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (fifo_empty) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end

                ABORT_WAIT: begin
                    // Wait out the read already in flight so the RAM read
                    // FIFO is left empty for the next transfer.
                    if (ram_rd_data_pres) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end

                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/ram_stream_reader.md
RAM_STREAM_READER -- requirements
Module: ram_stream_reader

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 16, output byte-FIFO entries (power of 2, ≥4).
REQ-002 SHALL have parameter MAX_BYTE_ADDR, default 26'h1FFFFFF, last valid byte address of the RAM port.
REQ-003 SHALL use one clock and an asynchronous, active-low reset: clk  in  1  rising-edge clock, same clock as the RAM port command/data clocks.
REQ-004 reset  in  1  asynchronous, active-low.
REQ-005 start  in  1  one-cycle pulse; begins a transfer.
REQ-006 start_addr  in  26  first byte address.
REQ-007 end_addr  in  26  last byte address, inclusive.
REQ-008 abort  in  1  one-cycle pulse; cancels a transfer.
REQ-009 busy  out  1  high from accepted start until IDLE.
REQ-010 done  out  1  one-cycle pulse when the last byte has left the FIFO.
REQ-011 ram_rdy  in  1  RAM calibration complete.
REQ-012 ram_address  out  26  byte address to the RAM port.
REQ-013 ram_read_request  out  1  one-cycle read command.
REQ-014 ram_rd_data_pres  in  1  RAM read FIFO non-empty.
REQ-015 ram_read_ack  out  1  one-cycle pop of the RAM read FIFO.
REQ-016 ram_data  in  8  byte selected by the RAM port from ram_address.
REQ-017 out_data  out  8; out_valid  out  1; out_ready  in  1  byte stream to the decoder feeder.

Function
REQ-018 FSM states SHALL be IDLE, ISSUE, WAIT_DATA, DRAIN, ABORT_WAIT.
REQ-019 IDLE: start SHALL latch start_addr into cur_addr and end_addr into last_addr, set busy, and go to ISSUE; start while busy SHALL be ignored.
REQ-020 ISSUE: when ram_rdy=1 and FIFO count < FIFO_DEPTH, SHALL pulse ram_read_request for one cycle with ram_address=cur_addr, then go to WAIT_DATA; otherwise SHALL stay in ISSUE.
REQ-021 ram_address SHALL stay stable from the request cycle through the ram_read_ack cycle, because the byte select is combinational on the address.
REQ-022 Only one read SHALL be outstanding at a time.
REQ-023 WAIT_DATA: on ram_rd_data_pres=1, SHALL in the same cycle write ram_data into the FIFO and pulse ram_read_ack.
REQ-024 After that write, if cur_addr==last_addr the block SHALL go to DRAIN; otherwise it SHALL go to ISSUE with cur_addr incremented.
REQ-025 The address increment SHALL wrap MAX_BYTE_ADDR→0; start_addr>end_addr is legal and wraps.
REQ-026 Minimum cost SHALL be 3 cycles per byte (ISSUE, WAIT_DATA, ack) plus RAM latency.
REQ-027 DRAIN: when the FIFO is empty, SHALL pulse done for one cycle, clear busy, and go to IDLE.
REQ-028 Output handshake: a byte transfers when out_valid&&out_ready.
REQ-029 out_valid SHALL equal FIFO non-empty; out_data SHALL be the FIFO head, stable while out_valid&&!out_ready.
REQ-030 A simultaneous FIFO push and pop SHALL keep the count unchanged; a push SHALL never occur while the FIFO is full (guaranteed by REQ-020).
REQ-031 abort in IDLE or DRAIN: SHALL flush the FIFO and return to IDLE the next cycle; no done.
REQ-032 abort in ISSUE: same as REQ-031, and no request is issued that cycle.
REQ-033 abort in WAIT_DATA: SHALL go to ABORT_WAIT; on ram_rd_data_pres it SHALL pulse ram_read_ack, discard the byte, flush, and go to IDLE, so the RAM read FIFO is left empty.
REQ-034 abort coincident with start in IDLE: abort SHALL win.
REQ-035 ram_rdy falling mid-transfer: SHALL hold in ISSUE; an outstanding read SHALL still complete.

Reset
REQ-036 Reset SHALL return the FSM to IDLE, empty the FIFO, zero cur_addr and last_addr, and drive busy, done, ram_read_request, ram_read_ack, out_valid and ram_address to 0.
REQ-037 Reset asserted mid-transfer SHALL abandon the transfer without done; the RAM interface is reset by the same system reset.

Structure
REQ-038 Package ram_stream_pkg SHALL hold the state enumeration and the default MAX_BYTE_ADDR constant.
REQ-039 The byte FIFO SHALL be a sub-module sync_byte_fifo (depth/width parameters; count, full and empty outputs; synchronous flush input).

Verification
REQ-040 Bench SHALL cover: start 0x000100..0x000103, RAM model returning addr[7:0], out_ready=1 -> out bytes 00,01,02,03 then one done pulse; exactly 4 requests and 4 acks.
REQ-041 Bench SHALL cover: out_ready=0, range 0x0..0x3F, FIFO_DEPTH=16 -> exactly 16 requests then stall in ISSUE; releasing out_ready completes 64 bytes in order.
REQ-042 Bench SHALL cover: start 0x1FFFFFE..0x000001 -> addresses 1FFFFFE, 1FFFFFF, 0000000, 0000001, then done.
REQ-043 Bench SHALL cover: abort during WAIT_DATA with RAM latency 10 -> one ack after data arrives, out_valid=0, busy low, no done, RAM FIFO empty.
REQ-044 Bench SHALL cover: ram_rdy=0 at start, raised after 50 cycles -> no request before ram_rdy, normal completion after.
REQ-045 Bench SHALL cover: reset asserted mid-DRAIN -> all outputs 0 asynchronously, a new start works normally afterwards.
